// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-register enable/flush strobes, mem-wait/drain/halt FSM
// with drain watchdog. Performance counters are built only when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int          CNT_W     = 32,
    parameter int unsigned DRAIN_MAX = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             branch_ex,
    input  logic             load_use,
    input  logic             halt_mem,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             halt,
    output logic             drain_err,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] dstall_cnt,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_e;

    localparam int IFID = 0, IDEX = 1, EXMEM = 2, MEMWB = 3;
    // Watchdog fires on the DRAIN cycle that brings the count up to DRAIN_MAX.
    localparam logic [CNT_W-1:0] DOG_AT = CNT_W'(DRAIN_MAX - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             halt_q, halt_d;
    logic             err_q, err_d;
    logic             mstall;
    logic             pc;
    logic [3:0]       en, fl;

    assign mstall = dmem_req & ~dhit;

    always_comb begin
        pc = 1'b1;
        en = 4'b1111;
        fl = 4'b0000;
        if (RST) begin
            pc = 1'b0;
            en = 4'b0000;
            fl = 4'b1111;
        end else if (state_q == HALTED) begin
            pc = 1'b0;
            en = 4'b0000;
        end else begin
            if (mstall) begin
                pc        = 1'b0;
                en[IFID]  = 1'b0;
                en[IDEX]  = 1'b0;
                en[EXMEM] = 1'b0;
                fl[MEMWB] = 1'b1;
            end else if (branch_ex) begin
                fl[IFID] = 1'b1;
                fl[IDEX] = 1'b1;
            end else if (load_use) begin
                pc       = 1'b0;
                en[IFID] = 1'b0;
                fl[IDEX] = 1'b1;
            end else if (!ihit) begin
                pc       = 1'b0;
                fl[IFID] = 1'b1;
            end
            // Draining: fetch is shut off, younger stages keep following the hazard rules.
            if (state_q == DRAIN) begin
                pc       = 1'b0;
                fl[IFID] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        halt_d      = halt_q;
        err_d       = err_q;
        unique case (state_q)
            RUN, DWAIT: begin
                if (halt_wb)                        state_d = HALTED;
                else if (state_q == DWAIT && !dhit) state_d = DWAIT;
                else if (mstall)                    state_d = DWAIT;
                else if (halt_mem) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else                            state_d = RUN;
            end
            DRAIN: begin
                if (drain_cnt_q != '1) drain_cnt_d = drain_cnt_q + CNT_W'(1);
                if (halt_wb) state_d = HALTED;
                else if (drain_cnt_q >= DOG_AT) begin
                    state_d = HALTED;
                    err_d   = 1'b1;
                end
            end
            default: state_d = HALTED;
        endcase
        if (state_d == HALTED) halt_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halt_q      <= halt_d;
            err_q       <= err_d;
        end
    end

    assign pc_en        = pc;
    assign if_id_en     = en[IFID];
    assign id_ex_en     = en[IDEX];
    assign ex_mem_en    = en[EXMEM];
    assign mem_wb_en    = en[MEMWB];
    assign if_id_flush  = fl[IFID];
    assign id_ex_flush  = fl[IDEX];
    assign ex_mem_flush = fl[EXMEM];
    assign mem_wb_flush = fl[MEMWB];
    assign halt         = halt_q;
    assign drain_err    = err_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] cyc_q, dst_q, ist_q, flc_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cyc_q <= '0;
            dst_q <= '0;
            ist_q <= '0;
            flc_q <= '0;
        end else if (state_q != HALTED) begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (mstall) dst_q <= dst_q + CNT_W'(1);
            if (!mstall && branch_ex) flc_q <= flc_q + CNT_W'(1);
            if (!mstall && !branch_ex && !load_use && !ihit) ist_q <= ist_q + CNT_W'(1);
        end
    end

    assign cyc_cnt    = cyc_q;
    assign dstall_cnt = dst_q;
    assign istall_cnt = ist_q;
    assign flush_cnt  = flc_q;
`else
    assign cyc_cnt    = '0;
    assign dstall_cnt = '0;
    assign istall_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl: rule-level reference model compared every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W     = 32;
    localparam int DRAIN_MAX = 8;

    logic CLK = 1'b0;
    logic RST, ihit, dmem_req, dhit, branch_ex, load_use, halt_mem, halt_wb;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halt, drain_err;
    logic [CNT_W-1:0] cyc_cnt, dstall_cnt, istall_cnt, flush_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: flags and plain integer counts derived from the rules.
    bit             model_ok = 1'b0;
    bit             m_halted, m_waiting, m_draining, m_err;
    int             m_dcyc;
    bit [CNT_W-1:0] m_cyc, m_dst, m_ist, m_fl;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_MAX(DRAIN_MAX)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .branch_ex(branch_ex), .load_use(load_use), .halt_mem(halt_mem), .halt_wb(halt_wb),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .halt(halt),
        .drain_err(drain_err), .cyc_cnt(cyc_cnt), .dstall_cnt(dstall_cnt),
        .istall_cnt(istall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input bit r, ih, dr, dh, br, lu, hm, hw);
        RST = r; ihit = ih; dmem_req = dr; dhit = dh;
        branch_ex = br; load_use = lu; halt_mem = hm; halt_wb = hw;
    endtask

    function automatic bit rb(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic rnd_drive(input bit r);
        drive(r, rb(80), rb(30), rb(50), rb(15), rb(20), rb(4), rb(2));
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle compare, then advance the model to what the next posedge must produce.
    always @(negedge CLK) begin
        logic       stall, exp_pc;
        logic [3:0] exp_en, exp_fl, act_en, act_fl, mask;
        stall = dmem_req & ~dhit;
        if (model_ok) begin
            vectors++;
            exp_pc = 1'b1; exp_en = 4'b1111; exp_fl = 4'b0000;
            if (RST) begin
                exp_pc = 1'b0; exp_en = 4'b0000; exp_fl = 4'b1111;
            end else if (m_halted) begin
                exp_pc = 1'b0; exp_en = 4'b0000;
            end else begin
                if (stall) begin
                    exp_pc = 1'b0; exp_en = 4'b1000; exp_fl = 4'b1000;
                end else if (branch_ex) begin
                    exp_fl = 4'b0011;
                end else if (load_use) begin
                    exp_pc = 1'b0; exp_en = 4'b1110; exp_fl = 4'b0010;
                end else if (!ihit) begin
                    exp_pc = 1'b0; exp_fl = 4'b0001;
                end
                if (m_draining) begin
                    exp_pc = 1'b0; exp_fl[0] = 1'b1;
                end
            end
            act_en = {mem_wb_en, ex_mem_en, id_ex_en, if_id_en};
            act_fl = {mem_wb_flush, ex_mem_flush, id_ex_flush, if_id_flush};
            mask   = RST ? 4'b1111 : ~exp_fl;
            if (pc_en !== exp_pc) begin
                miscompares++; $display("FAIL pc_en @%0t: got %b expected %b", $time, pc_en, exp_pc);
            end
            if ((act_en & mask) !== (exp_en & mask)) begin
                miscompares++; $display("FAIL en @%0t: got %b expected %b mask %b", $time, act_en, exp_en, mask);
            end
            if (act_fl !== exp_fl) begin
                miscompares++; $display("FAIL flush @%0t: got %b expected %b", $time, act_fl, exp_fl);
            end
            if (halt !== m_halted || drain_err !== m_err) begin
                miscompares++;
                $display("FAIL halt/err @%0t: got %b%b expected %b%b", $time, halt, drain_err, m_halted, m_err);
            end
`ifdef PIPE_PERF_EN
            if ({cyc_cnt, dstall_cnt, istall_cnt, flush_cnt} !== {m_cyc, m_dst, m_ist, m_fl}) begin
`else
            if ({cyc_cnt, dstall_cnt, istall_cnt, flush_cnt} !== '0) begin
`endif
                miscompares++;
                $display("FAIL counters @%0t: got %0d/%0d/%0d/%0d model %0d/%0d/%0d/%0d", $time,
                         cyc_cnt, dstall_cnt, istall_cnt, flush_cnt, m_cyc, m_dst, m_ist, m_fl);
            end
        end
        if (RST) begin
            model_ok = 1'b1;
            m_halted = 1'b0; m_waiting = 1'b0; m_draining = 1'b0; m_err = 1'b0; m_dcyc = 0;
            m_cyc = '0; m_dst = '0; m_ist = '0; m_fl = '0;
        end else if (model_ok && !m_halted) begin
            m_cyc++;
            if (stall) m_dst++;
            else if (branch_ex) m_fl++;
            else if (!load_use && !ihit) m_ist++;
            if (halt_wb) m_halted = 1'b1;
            else if (m_draining) begin
                m_dcyc++;
                if (m_dcyc == DRAIN_MAX) begin
                    m_halted = 1'b1; m_err = 1'b1;
                end
            end else if (m_waiting && !dhit) begin
                m_waiting = 1'b1;
            end else begin
                m_waiting = stall;
                if (!stall && halt_mem) begin
                    m_draining = 1'b1; m_dcyc = 0;
                end
            end
        end
    end

    initial begin
        // Reset with random inputs: everything flushed, nothing enabled.
        for (int i = 0; i < 2; i++) begin
            rnd_drive(1'b1);
            @(negedge CLK);
            lit("rst_flush", {mem_wb_flush, ex_mem_flush, id_ex_flush, if_id_flush}, 4'hf);
            lit("rst_en", {mem_wb_en, ex_mem_en, id_ex_en, if_id_en}, 4'h0);
            lit("rst_pc", pc_en, 0);
            tick;
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        lit("run_en", {pc_en, mem_wb_en, ex_mem_en, id_ex_en, if_id_en}, 5'h1f);
        lit("run_flush", {mem_wb_flush, ex_mem_flush, id_ex_flush, if_id_flush}, 4'h0);
        tick;

        // Three cycles of data-cache miss, then the hit.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 0, 0, 0, 0);
            @(negedge CLK);
            lit("dstall_frz", {pc_en, ex_mem_en, id_ex_en, if_id_en}, 4'h0);
            lit("dstall_mwf", mem_wb_flush, 1);
            tick;
        end
        drive(0, 1, 1, 1, 0, 0, 0, 0);
        @(negedge CLK);
        lit("dhit_en", {pc_en, mem_wb_en, ex_mem_en, id_ex_en, if_id_en}, 5'h1f);
        lit("dhit_flush", {mem_wb_flush, ex_mem_flush, id_ex_flush, if_id_flush}, 4'h0);
`ifdef PIPE_PERF_EN
        lit("dstall_cnt", dstall_cnt, 3);
        lit("cyc_cnt", cyc_cnt, 4);
`endif
        tick;

        // Branch together with load-use resolves as branch.
        drive(0, 1, 0, 0, 1, 1, 0, 0);
        @(negedge CLK);
        lit("br_pc", pc_en, 1);
        lit("br_flush", {if_id_flush, id_ex_flush}, 2'b11);
        lit("br_exmem_en", ex_mem_en, 1);
        tick;
        drive(0, 1, 0, 0, 0, 1, 0, 0);
        @(negedge CLK);
        lit("lu_pc_ifid", {pc_en, if_id_en}, 2'b00);
        lit("lu_idex_fl", id_ex_flush, 1);
        lit("lu_en", {ex_mem_en, mem_wb_en}, 2'b11);
`ifdef PIPE_PERF_EN
        lit("flush_cnt", flush_cnt, 1);
`endif
        tick;

        // Halt drain completed by halt_wb two cycles after halt_mem.
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        tick;
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        lit("drain_pc_fl", {pc_en, if_id_flush}, 2'b01);
        tick;
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        lit("drain2_pc_fl", {pc_en, if_id_flush}, 2'b01);
        lit("drain2_halt", halt, 0);
        tick;
        for (int i = 0; i < 10; i++) begin
            rnd_drive(1'b0);
            @(negedge CLK);
            lit("halted", {halt, drain_err, pc_en}, 3'b100);
            tick;
        end

        // Watchdog: halt_wb never arrives.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick;
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        tick;
        for (int i = 0; i < DRAIN_MAX; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 0);
            @(negedge CLK);
            lit("wd_wait", halt, 0);
            tick;
        end
        @(negedge CLK);
        lit("wd_fired", {halt, drain_err}, 2'b11);
        tick;
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick;
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        lit("wd_cleared", {halt, drain_err}, 2'b00);
        tick;

        // Random episodes, each opened by a reset, with occasional resets mid-flight.
        for (int e = 0; e < 30; e++) begin
            rnd_drive(1'b1);
            tick;
            rnd_drive(1'b1);
            tick;
            for (int c = 0; c < 60; c++) begin
                rnd_drive(rb(2));
                tick;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control-side counterpart of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It generates every `*_en` and `*_flush` strobe they consume, plus `pc_en`.
- Inputs are cache handshakes (`ihit`, `dmem_req`/`dhit`), hazard detections (EX branch redirect, load-use) and halt progress.
- A small FSM owns data-memory waits, halt drain and the final halted state, with a drain watchdog.

Parameters:
- CNT_W, 32, width of the drain counter and the performance counters.
- DRAIN_MAX, 8, maximum cycles in DRAIN before the watchdog fires; legal range 1..2^CNT_W-1.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction cache hit; fetch completes this cycle.
- dmem_req  in  1  MEM stage holds a load or store.
- dhit  in  1  data cache completes the MEM access this cycle.
- branch_ex  in  1  EX resolved a taken branch or jump; PC loads the target.
- load_use  in  1  ID instruction needs the result of the load in EX.
- halt_mem  in  1  halt instruction is in MEM.
- halt_wb  in  1  halt instruction is in WB.
- pc_en  out  1  PC update enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (all-zero word) into the register.
- halt  out  1  sticky; processor halted.
- drain_err  out  1  sticky; watchdog fired.
- cyc_cnt, dstall_cnt, istall_cnt, flush_cnt  out  CNT_W each  performance counters (see Optional Feature).

Behaviour:
- Outputs are combinational from state and inputs. The only registered elements are the state, `drain_cnt`, the sticky `halt`/`drain_err` bits and the counters.
- Base outputs, RUN with no hazard: all `en`=1, all `flush`=0, `pc_en`=1.
- Hazard priority in RUN/DWAIT, highest first:
  - (1) Memory stall, `dmem_req & ~dhit`: `pc_en` and the IF/ID, ID/EX and EX/MEM enables = 0; `mem_wb_flush`=1.
  - (2) `branch_ex`: `pc_en`=1; `if_id_flush`=1; `id_ex_flush`=1.
  - (3) `load_use`: `pc_en`=0; `if_id_en`=0; `id_ex_flush`=1.
  - (4) `~ihit`: `pc_en`=0; `if_id_flush`=1.
  - Where a flush is asserted, the corresponding `en` is don't-care. Registers give flush priority over en.
- FSM states and transitions:
  - RUN → DWAIT when `dmem_req & ~dhit`.
  - RUN → DRAIN when `halt_mem` and there is no memory stall.
  - RUN → HALTED when `halt_wb`.
  - DWAIT: stays while `~dhit`. On `dhit`, goes to RUN; that same cycle uses RUN outputs, so the pipe advances.
  - DRAIN: `pc_en`=0 and `if_id_flush`=1 every cycle; the rest follows the priority rules. `drain_cnt` increments per cycle.
  - DRAIN → HALTED on `halt_wb`.
  - DRAIN → HALTED with `drain_err`=1 when `drain_cnt` reaches DRAIN_MAX without `halt_wb`.
  - HALTED: all `en`=0, all `flush`=0, `pc_en`=0, `halt`=1. Exits only via RST.
- Simultaneous events:
  - `halt_wb` beats any stall.
  - `halt_mem` during a memory stall is ignored until `dhit`.
  - `branch_ex` together with `load_use` resolves as branch only.
- Reset, including mid-DWAIT or mid-DRAIN, takes effect the cycle RST is sampled high:
  - state=RUN, `drain_cnt`=0, `halt`=0, `drain_err`=0, counters=0.
  - While RST=1: all `en`=0, all `flush`=1, `pc_en`=0.
- `drain_cnt` saturates and never wraps.

Optional Feature:
- Macro: `PIPE_PERF_EN`.
- Defined:
  - `cyc_cnt` increments every non-HALTED cycle.
  - `dstall_cnt` increments per memory-stall cycle.
  - `istall_cnt` increments per cycle where rule (4) wins.
  - `flush_cnt` increments per cycle with `branch_ex` applied.
  - All counters wrap modulo 2^CNT_W and freeze in HALTED.
- Undefined: the counter ports remain and are tied to 0, and no counter flops are built.

Test Plan:
- RST=1 for 2 cycles with random inputs → all `flush`=1, `en`=0, `pc_en`=0; first cycle after RST=0 with `ihit`=1 → all `en`=1, `pc_en`=1.
- `dmem_req`=1, `dhit`=0 for 3 cycles, then `dhit`=1 → 3 cycles of freeze plus `mem_wb_flush`=1; cycle 4 all `en`=1; (PIPE_PERF_EN) `dstall_cnt`=3.
- `branch_ex`=1 and `load_use`=1 together with `ihit`=1 → `pc_en`=1, `if_id_flush`=1, `id_ex_flush`=1, `ex_mem_en`=1; `flush_cnt` +1.
- `load_use`=1 only → `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1, `ex_mem_en`=1, `mem_wb_en`=1.
- `halt_mem` pulse, then `halt_wb` 2 cycles later → DRAIN shows `pc_en`=0 and `if_id_flush`=1; then `halt`=1 and stays 1 for 10 further cycles; `drain_err`=0.
- `halt_mem` with `halt_wb` never asserted, DRAIN_MAX=8 → `halt`=1 and `drain_err`=1 after 8 DRAIN cycles; RST then clears both.
